// File: rtl/oci_dbg_pkg.sv
// Shared types and constants for the OCI debug memory access arbiter.
// Grant encoding, FSM states and JTAG data-word field positions.
package oci_dbg_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_JDO_W  = 38;

    localparam int JDO_ADDR_LSB  = 0;
    localparam int JDO_WDATA_LSB = 3;

    localparam logic GNT_JTAG = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CMPL = 2'd2
    } state_e;

endpackage

// File: rtl/oci_dbg_rr_arb2.sv
// Two-way round-robin decision between the JTAG and host requesters.
// Holds the previous grant whenever no decision is being taken.
module oci_dbg_rr_arb2
    import oci_dbg_pkg::*;
(
    input  logic req_j,
    input  logic req_h,
    input  logic last_grant,
    input  logic update,
    output logic grant
);

    always_comb begin
        grant = last_grant;
        if (update) begin
            unique case (1'b1)
                (req_j && req_h):
                    grant = (last_grant == GNT_HOST) ? GNT_JTAG : GNT_HOST;
                (req_j && !req_h):
                    grant = GNT_JTAG;
                (!req_j && req_h):
                    grant = GNT_HOST;
                default:
                    grant = last_grant;
            endcase
        end
    end

endmodule

// File: rtl/oci_debug_access_arb.sv
// Arbitrates the OCI debug memory between JTAG commands and a host port.
// Every access is IDLE (decide) -> ACC (strobe) -> CMPL (return data).
module oci_debug_access_arb
    import oci_dbg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int JDO_W  = DEF_JDO_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state_q;
    state_e state_d;

    logic last_grant;
    logic grant;
    logic host_req;
    logic arb_update;
    logic jtag_cmpl;
    logic cmd_any;
    logic cmd_open;

    logic              jpend;
    logic              jwr;
    logic [ADDR_W-1:0] jaddr;
    logic [DATA_W-1:0] jwdata;

    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic unused_jdo;
    assign unused_jdo = ^jdo;

    assign host_req   = avs_read | avs_write;
    assign arb_update = (state_q == ST_IDLE) && (jpend || host_req);
    assign jtag_cmpl  = (state_q == ST_CMPL) && (last_grant == GNT_JTAG);
    assign cmd_any    = take_action_ocimem_a | take_action_ocimem_b;
    // The completing JTAG access frees the slot in the same cycle.
    assign cmd_open   = !jpend || jtag_cmpl;

    oci_dbg_rr_arb2 u_rr (
        .req_j      (jpend),
        .req_h      (host_req),
        .last_grant (last_grant),
        .update     (arb_update),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_grant <= GNT_HOST;
        end else begin
            state_q    <= state_d;
            last_grant <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_wr    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (arb_update) begin
            if (grant == GNT_HOST) begin
                acc_wr    <= avs_write;
                acc_addr  <= avs_address;
                acc_wdata <= avs_writedata;
            end else begin
                acc_wr    <= jwr;
                acc_addr  <= jaddr;
                acc_wdata <= jwdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jpend         <= 1'b0;
            jwr           <= 1'b0;
            jaddr         <= '0;
            jwdata        <= '0;
            monitor_error <= 1'b0;
        end else begin
            if (jtag_cmpl) begin
                jpend <= 1'b0;
                jaddr <= jaddr + ADDR_W'(1);
            end
            // A new read address overrides the post-access increment.
            if (cmd_any) begin
                if (cmd_open) begin
                    jpend         <= 1'b1;
                    jwr           <= take_action_ocimem_b;
                    monitor_error <= take_action_ocimem_a &
                                     take_action_ocimem_b;
                    if (take_action_ocimem_b)
                        jwdata <= jdo[JDO_WDATA_LSB +: DATA_W];
                    else
                        jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                end else begin
                    monitor_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
        end else begin
            monitor_ready <= jtag_cmpl;
            if (jtag_cmpl)
                MonDReg <= acc_wr ? acc_wdata : mem_rdata;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_addr        = acc_addr;
        mem_wdata       = acc_wdata;
        avs_waitrequest = host_req;
        avs_readdata    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_update)
                    state_d = ST_ACC;
            end
            ST_ACC: begin
                state_d = ST_CMPL;
                mem_rd  = !acc_wr;
                mem_wr  = acc_wr;
            end
            ST_CMPL: begin
                state_d = ST_IDLE;
                if (last_grant == GNT_HOST) begin
                    avs_waitrequest = 1'b0;
                    avs_readdata    = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_oci_debug_access_arb.sv
// Bench for oci_debug_access_arb: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbiter.
module tb_oci_debug_access_arb;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        take_a;
    logic        take_b;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    oci_debug_access_arb dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .jdo                  (jdo),
        .MonDReg              (MonDReg),
        .monitor_ready        (monitor_ready),
        .monitor_error        (monitor_error),
        .avs_address          (avs_address),
        .avs_read             (avs_read),
        .avs_write            (avs_write),
        .avs_writedata        (avs_writedata),
        .avs_readdata         (avs_readdata),
        .avs_waitrequest      (avs_waitrequest),
        .mem_addr             (mem_addr),
        .mem_rd               (mem_rd),
        .mem_wr               (mem_wr),
        .mem_wdata            (mem_wdata),
        .mem_rdata            (mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 16)
            return 32'hCAFE0001;
        return {8'hA5, 8'(i), 8'(~i), 8'(i + 60)};
    endfunction

    logic [31:0] tb_mem [256];
    bit mem_reinit = 1'b0;

    always @(posedge clk) begin
        if (mem_reinit) begin
            for (int i = 0; i < 256; i++)
                tb_mem[i] <= init_word(i);
        end else if (mem_wr) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd)
            mem_rdata <= tb_mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        take_a        = 1'b0;
        take_b        = 1'b0;
        jdo           = '0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        avs_read = 1'b1;
        tick();
        tick();
        #1;
        total += 6;
        if (mem_rd !== 1'b0) begin
            bad++; $display("FAIL rst_mem_rd act=%b exp=0", mem_rd);
        end
        if (mem_wr !== 1'b0) begin
            bad++; $display("FAIL rst_mem_wr act=%b exp=0", mem_wr);
        end
        if (MonDReg !== 32'h0) begin
            bad++; $display("FAIL rst_mondreg act=%h exp=0", MonDReg);
        end
        if (monitor_ready !== 1'b0) begin
            bad++; $display("FAIL rst_ready act=%b exp=0", monitor_ready);
        end
        if (monitor_error !== 1'b0) begin
            bad++; $display("FAIL rst_error act=%b exp=0", monitor_error);
        end
        if (avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rst_wait_req act=%b exp=1", avs_waitrequest);
        end
        avs_read = 1'b0;
        #1;
        total++;
        if (avs_waitrequest !== 1'b0) begin
            bad++; $display("FAIL rst_wait_noreq act=%b exp=0", avs_waitrequest);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_jtag_read();
        do_reset();
        jdo = 38'h10;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        #1;
        total++;
        if (mem_rd !== 1'b0) begin
            bad++; $display("FAIL jr_early_rd act=%b exp=0", mem_rd);
        end
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 8'h10) begin
            bad++; $display("FAIL jr_acc rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=10",
                            mem_rd, mem_wr, mem_addr);
        end
        tick();
        total++;
        if (mem_rd !== 1'b0 || monitor_ready !== 1'b0) begin
            bad++; $display("FAIL jr_cmpl rd=%b rdy=%b exp 0 0", mem_rd, monitor_ready);
        end
        tick();
        total++;
        if (monitor_ready !== 1'b1 || MonDReg !== 32'hCAFE0001) begin
            bad++; $display("FAIL jr_done rdy=%b mon=%h exp 1 cafe0001",
                            monitor_ready, MonDReg);
        end
        jdo = {3'b0, 32'hDEADBEEF, 3'b0};
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        #1;
        total++;
        if (monitor_ready !== 1'b0) begin
            bad++; $display("FAIL jr_ready_pulse act=%b exp=0", monitor_ready);
        end
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL jr_incr wr=%b addr=%h data=%h exp 1 11 deadbeef",
                            mem_wr, mem_addr, mem_wdata);
        end
        tick();
        tick();
        total++;
        if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin
            bad++; $display("FAIL jw_done rdy=%b mon=%h exp 1 deadbeef",
                            monitor_ready, MonDReg);
        end
    endtask

    task automatic test_host_write();
        do_reset();
        avs_address   = 8'h20;
        avs_writedata = 32'h12345678;
        avs_write     = 1'b1;
        #1;
        total++;
        if (avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL hw_wait1 act=%b exp=1", avs_waitrequest);
        end
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 8'h20 ||
            mem_wdata !== 32'h12345678 || avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL hw_acc wr=%b rd=%b addr=%h data=%h wait=%b exp 1 0 20 12345678 1",
                            mem_wr, mem_rd, mem_addr, mem_wdata, avs_waitrequest);
        end
        tick();
        total++;
        if (avs_waitrequest !== 1'b0 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL hw_cmpl wait=%b wr=%b exp 0 0", avs_waitrequest, mem_wr);
        end
        tick();
        avs_write = 1'b0;
        #1;
        total++;
        if (tb_mem[8'h20] !== 32'h12345678) begin
            bad++; $display("FAIL hw_mem act=%h exp=12345678", tb_mem[8'h20]);
        end
    endtask

    task automatic test_tie();
        do_reset();
        jdo = {3'b0, 32'h0000AAAA, 3'b0};
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        avs_address = 8'h30;
        avs_read = 1'b1;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 8'h00) begin
            bad++; $display("FAIL tie1_jtag wr=%b rd=%b addr=%h exp 1 0 00",
                            mem_wr, mem_rd, mem_addr);
        end
        tick();
        total++;
        if (avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL tie1_hold act=%b exp=1", avs_waitrequest);
        end
        jdo = 38'h44;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        #1;
        total++;
        if (monitor_ready !== 1'b1 || MonDReg !== 32'h0000AAAA ||
            avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL tie1_done rdy=%b mon=%h wait=%b exp 1 0000aaaa 1",
                            monitor_ready, MonDReg, avs_waitrequest);
        end
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h30) begin
            bad++; $display("FAIL tie2_host rd=%b addr=%h exp 1 30", mem_rd, mem_addr);
        end
        tick();
        total++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== init_word(8'h30)) begin
            bad++; $display("FAIL tie2_data wait=%b data=%h exp 0 %h",
                            avs_waitrequest, avs_readdata, init_word(8'h30));
        end
        tick();
        avs_read = 1'b0;
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h44) begin
            bad++; $display("FAIL tie2_jtag rd=%b addr=%h exp 1 44", mem_rd, mem_addr);
        end
        tick();
        tick();
        total++;
        if (monitor_ready !== 1'b1 || MonDReg !== init_word(8'h44)) begin
            bad++; $display("FAIL tie2_done rdy=%b mon=%h exp 1 %h",
                            monitor_ready, MonDReg, init_word(8'h44));
        end
    endtask

    task automatic test_overflow_wrap();
        do_reset();
        jdo = 38'hFE;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        jdo = {3'b0, 32'h11111111, 3'b0};
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        #1;
        total++;
        if (monitor_error !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 8'hFE) begin
            bad++; $display("FAIL ov_drop err=%b rd=%b addr=%h exp 1 1 fe",
                            monitor_error, mem_rd, mem_addr);
        end
        tick();
        tick();
        total++;
        if (MonDReg !== init_word(8'hFE) || monitor_error !== 1'b1) begin
            bad++; $display("FAIL ov_keep mon=%h err=%b exp %h 1",
                            MonDReg, monitor_error, init_word(8'hFE));
        end
        jdo = {3'b0, 32'h0BADF00D, 3'b0};
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        #1;
        total++;
        if (monitor_error !== 1'b0) begin
            bad++; $display("FAIL ov_clear err=%b exp=0", monitor_error);
        end
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 32'h0BADF00D) begin
            bad++; $display("FAIL wrap_ff wr=%b addr=%h data=%h exp 1 ff 0badf00d",
                            mem_wr, mem_addr, mem_wdata);
        end
        tick();
        tick();
        jdo = {3'b0, 32'h600DCAFE, 3'b0};
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_addr !== 8'h00 || tb_mem[8'hFF] !== 32'h0BADF00D) begin
            bad++; $display("FAIL wrap_00 wr=%b addr=%h memff=%h exp 1 00 0badf00d",
                            mem_wr, mem_addr, tb_mem[8'hFF]);
        end
        tick();
        tick();
        jdo = {3'b0, 32'h51515151, 3'b0};
        take_a = 1'b1;
        take_b = 1'b1;
        tick();
        take_a = 1'b0;
        take_b = 1'b0;
        #1;
        total++;
        if (monitor_error !== 1'b1) begin
            bad++; $display("FAIL both_err act=%b exp=1", monitor_error);
        end
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 32'h51515151) begin
            bad++; $display("FAIL both_write wr=%b addr=%h data=%h exp 1 01 51515151",
                            mem_wr, mem_addr, mem_wdata);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        avs_address = 8'h40;
        avs_read = 1'b1;
        tick();
        total++;
        if (mem_rd !== 1'b1) begin
            bad++; $display("FAIL mid_acc rd=%b exp=1", mem_rd);
        end
        reset_n = 1'b0;
        tick();
        total++;
        if (mem_rd !== 1'b0 || avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL mid_abort rd=%b wait=%b exp 0 1", mem_rd, avs_waitrequest);
        end
        tick();
        total++;
        if (mem_rd !== 1'b0 || avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL mid_hold rd=%b wait=%b exp 0 1", mem_rd, avs_waitrequest);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h40 || avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL mid_restart rd=%b addr=%h wait=%b exp 1 40 1",
                            mem_rd, mem_addr, avs_waitrequest);
        end
        tick();
        total++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== init_word(8'h40)) begin
            bad++; $display("FAIL mid_done wait=%b data=%h exp 0 %h",
                            avs_waitrequest, avs_readdata, init_word(8'h40));
        end
        tick();
        avs_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        int host_t[$];
        int jtag_t[$];
        do_reset();
        avs_address = 8'h50;
        avs_read = 1'b1;
        jdo = {3'b0, 32'h77777777, 3'b0};
        take_b = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mem_rd) host_t.push_back(c);
            if (mem_wr) jtag_t.push_back(c);
            tick();
            take_b = monitor_ready;
        end
        take_b = 1'b0;
        avs_read = 1'b0;
        total += 2;
        if (host_t.size() < 5) begin
            bad++; $display("FAIL b2b_host_cnt act=%0d exp>=5", host_t.size());
        end
        if (jtag_t.size() < 5) begin
            bad++; $display("FAIL b2b_jtag_cnt act=%0d exp>=5", jtag_t.size());
        end
        for (int i = 1; i < host_t.size(); i++) begin
            total++;
            if (host_t[i] - host_t[i-1] != 6) begin
                bad++; $display("FAIL b2b_host_gap act=%0d exp=6", host_t[i] - host_t[i-1]);
            end
        end
        for (int i = 1; i < jtag_t.size(); i++) begin
            total++;
            if (jtag_t[i] - jtag_t[i-1] != 6) begin
                bad++; $display("FAIL b2b_jtag_gap act=%0d exp=6", jtag_t[i] - jtag_t[i-1]);
            end
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] rmem [256];
        logic [7:0]  ja, aaddr;
        logic [31:0] jd, awd, mon;
        logic [63:0] r;
        bit jp, jwr, err, rdy, last_h, own_h, awr, h_act;
        bit a, b, hreq, open_slot, exp_wait;
        int age, kind;

        mem_reinit = 1'b1;
        do_reset();
        mem_reinit = 1'b0;
        for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
        jp = 0; jwr = 0; err = 0; rdy = 0; last_h = 1; own_h = 0;
        awr = 0; h_act = 0; age = 0;
        ja = '0; jd = '0; mon = '0; aaddr = '0; awd = '0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!h_act && $urandom_range(2) == 0) begin
                h_act = 1;
                kind = int'($urandom_range(2));
                avs_read      = (kind != 1);
                avs_write     = (kind != 0);
                avs_address   = 8'($urandom);
                avs_writedata = $urandom;
            end
            a = ($urandom_range(7) == 0);
            b = ($urandom_range(7) == 0);
            r = {$urandom, $urandom};
            jdo = r[37:0];
            take_a = a;
            take_b = b;
            #1;
            hreq = avs_read | avs_write;
            exp_wait = hreq && !(age == 2 && own_h);

            total += 6;
            if (mem_rd !== (age == 1 && !awr)) begin
                bad++; $display("FAIL rnd_rd c=%0d act=%b exp=%b", cyc, mem_rd, age == 1 && !awr);
            end
            if (mem_wr !== (age == 1 && awr)) begin
                bad++; $display("FAIL rnd_wr c=%0d act=%b exp=%b", cyc, mem_wr, age == 1 && awr);
            end
            if (avs_waitrequest !== exp_wait) begin
                bad++; $display("FAIL rnd_wait c=%0d act=%b exp=%b", cyc, avs_waitrequest, exp_wait);
            end
            if (MonDReg !== mon) begin
                bad++; $display("FAIL rnd_mon c=%0d act=%h exp=%h", cyc, MonDReg, mon);
            end
            if (monitor_ready !== rdy) begin
                bad++; $display("FAIL rnd_ready c=%0d act=%b exp=%b", cyc, monitor_ready, rdy);
            end
            if (monitor_error !== err) begin
                bad++; $display("FAIL rnd_err c=%0d act=%b exp=%b", cyc, monitor_error, err);
            end
            if (age == 1) begin
                total++;
                if (mem_addr !== aaddr || (awr && mem_wdata !== awd)) begin
                    bad++; $display("FAIL rnd_acc c=%0d addr=%h data=%h exp %h %h",
                                    cyc, mem_addr, mem_wdata, aaddr, awd);
                end
            end
            if (age == 2 && own_h && !awr) begin
                total++;
                if (avs_readdata !== rmem[aaddr]) begin
                    bad++; $display("FAIL rnd_rdata c=%0d act=%h exp=%h",
                                    cyc, avs_readdata, rmem[aaddr]);
                end
            end

            rdy = 0;
            open_slot = !jp || (age == 2 && !own_h);
            if (age == 2) begin
                if (!own_h) begin
                    mon = awr ? awd : rmem[aaddr];
                    rdy = 1;
                    ja = ja + 8'd1;
                    jp = 0;
                end
                age = 0;
            end else if (age == 1) begin
                if (awr) rmem[aaddr] = awd;
                age = 2;
            end else if (jp || hreq) begin
                own_h  = hreq && (!jp || !last_h);
                last_h = own_h;
                awr    = own_h ? avs_write : jwr;
                aaddr  = own_h ? avs_address : ja;
                awd    = own_h ? avs_writedata : jd;
                age    = 1;
            end
            if (a || b) begin
                if (open_slot) begin
                    jp  = 1;
                    jwr = b;
                    err = a && b;
                    if (b) jd = jdo[34:3];
                    else   ja = jdo[7:0];
                end else begin
                    err = 1;
                end
            end

            tick();
            take_a = 1'b0;
            take_b = 1'b0;
            if (h_act && hreq && !exp_wait) begin
                h_act = 0;
                avs_read = 1'b0;
                avs_write = 1'b0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        mem_reinit = 1'b1;
        test_reset();
        mem_reinit = 1'b0;
        test_jtag_read();
        test_host_write();
        test_tie();
        test_overflow_wrap();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
